// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int          INST_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; flush empties it in one cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect/kill handling, next_pc mux.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] pc,
    output logic [INST_W-1:0] next_pc,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [INST_W-1:0] addr_q, addr_d;
    logic              push, pop, flush, buf_valid;
    logic [CNT_W-1:0]  count, post_count;
    fetch_entry_t      wr_entry, head;
    logic              unused_redirect_lsbs;

    assign pop                  = buf_valid & inst_ready;
    assign wr_entry             = '{pc: pc, inst: imem_rdata};
    assign post_count           = count + CNT_W'(1) - CNT_W'(pop);
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        next_pc = pc;
        push    = 1'b0;
        flush   = 1'b0;
        if (rst) begin
            next_pc = pc;
        end else if (redirect) begin
            // A redirect flushes the buffer; an in-flight request must still drain in KILL.
            next_pc = {redirect_pc[INST_W-1:2], 2'b00};
            flush   = 1'b1;
            if (state_q == WAIT || state_q == KILL) state_d = imem_ack ? IDLE : KILL;
            else                                    state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count < CNT_W'(DEPTH)) begin
                        state_d = WAIT;
                        addr_d  = pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        push    = 1'b1;
                        next_pc = pc + PC_STEP;
                        if (post_count < CNT_W'(DEPTH)) addr_d = pc + PC_STEP;
                        else                           state_d = IDLE;
                    end
                end
                KILL: begin
                    if (imem_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .valid    (buf_valid),
        .count    (count)
    );

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = buf_valid;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule
